// File: rtl/axi_stream_extract_header_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header extractor.
package axi_stream_extract_header_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } state_t;

  function automatic logic [7:0] popcount(input logic [MAX_BYTES-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  // Top n bits of a w-bit field set; callers truncate to w bits.
  function automatic logic [MAX_BYTES-1:0] msb_mask(input int unsigned n, input int unsigned w);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if ((i < w) && ((w - 1 - i) < n)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_BYTES-1:0] lsb_mask(input int unsigned n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_realign.sv
// Combines MSB-aligned residual bytes with the incoming beat and derives the next residual.
module axis_byte_realign #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0] i_res,
  input  logic [CNT_WD-1:0]  i_res_cnt,
  input  logic [DATA_WD-1:0] i_data,
  output logic [DATA_WD-1:0] o_data,
  output logic [DATA_WD-1:0] o_res_next
);

  localparam logic [CNT_WD-1:0] W_C = CNT_WD'(DATA_BYTE_WD);

  // Residual is zero below its R bytes, so an OR is enough to merge.
  assign o_data     = i_res | (i_data >> {i_res_cnt, 3'b000});
  assign o_res_next = i_data << {W_C - i_res_cnt, 3'b000};

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips an N-byte header off each AXI-Stream packet and realigns the payload.
// Optional packet counter output enabled by defining AXIS_EXTRACT_PKT_CNT_EN.
module axi_stream_extract_header
  import axi_stream_extract_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef AXIS_EXTRACT_PKT_CNT_EN
  output logic [15:0]             pkt_cnt,
`endif
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

  state_t                  r_state, w_state_nxt;
  logic [DATA_WD-1:0]      r_res, w_res_nxt;
  logic [CW-1:0]           r_res_cnt, w_res_cnt_nxt;
  logic [DATA_WD-1:0]      w_comb, w_res_shift;
  logic [CW-1:0]           w_n, w_b, w_rb, w_hdr_n;
  logic                    w_rdy_idle, w_hdr_load, w_pkt_done;
  logic                    r_valid_header;
  logic [DATA_WD-1:0]      r_data_header;
  logic [DATA_BYTE_WD-1:0] r_keep_header;

  assign w_n        = {1'b0, byte_extract_cnt} + {{BYTE_CNT_WD{1'b0}}, 1'b1};
  assign w_b        = CW'(popcount(MAX_BYTES'(keep_in)));
  assign w_rb       = r_res_cnt + w_b;
  assign w_rdy_idle = !r_valid_header || ready_header;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_WD       (CW)
  ) u_realign (
    .i_res      (r_res),
    .i_res_cnt  (r_res_cnt),
    .i_data     (data_in),
    .o_data     (w_comb),
    .o_res_next (w_res_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_res     <= '0;
      r_res_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_res     <= w_res_nxt;
      r_res_cnt <= w_res_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    ready_in      = 1'b0;
    valid_out     = 1'b0;
    data_out      = '0;
    keep_out      = '0;
    last_out      = 1'b0;
    w_hdr_load    = 1'b0;
    w_hdr_n       = w_n;
    w_res_nxt     = r_res;
    w_res_cnt_nxt = r_res_cnt;
    w_pkt_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready_in = w_rdy_idle;
        if (valid_in && w_rdy_idle) begin
          w_hdr_load = 1'b1;
          if (last_in && (w_b <= w_n)) begin
            // Short packet: everything goes to the header, no payload beat.
            w_hdr_n       = w_b;
            w_res_nxt     = '0;
            w_res_cnt_nxt = '0;
            w_pkt_done    = 1'b1;
          end else begin
            w_res_nxt = data_in << {w_n, 3'b000};
            if (last_in) begin
              w_res_cnt_nxt = w_b - w_n;
              w_state_nxt   = TAIL;
            end else begin
              w_res_cnt_nxt = W_C - w_n;
              w_state_nxt   = BODY;
            end
          end
        end
      end
      BODY: begin
        valid_out = valid_in;
        ready_in  = ready_out;
        data_out  = w_comb;
        keep_out  = '1;
        if (last_in && (w_rb <= W_C)) begin
          keep_out = DATA_BYTE_WD'(msb_mask(32'(w_rb), DATA_BYTE_WD));
          last_out = 1'b1;
          if (valid_in && ready_out) begin
            w_state_nxt = IDLE;
            w_pkt_done  = 1'b1;
          end
        end else if (valid_in && ready_out) begin
          w_res_nxt = w_res_shift;
          if (last_in) begin
            w_res_cnt_nxt = w_rb - W_C;
            w_state_nxt   = TAIL;
          end
        end
      end
      TAIL: begin
        valid_out = 1'b1;
        data_out  = r_res;
        keep_out  = DATA_BYTE_WD'(msb_mask(32'(r_res_cnt), DATA_BYTE_WD));
        last_out  = 1'b1;
        if (ready_out) begin
          w_state_nxt = IDLE;
          w_pkt_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Header channel: a new load wins over a same-cycle acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_header <= 1'b0;
      r_data_header  <= '0;
      r_keep_header  <= '0;
    end else if (w_hdr_load) begin
      r_valid_header <= 1'b1;
      r_data_header  <= data_in >> {W_C - w_hdr_n, 3'b000};
      r_keep_header  <= DATA_BYTE_WD'(lsb_mask(32'(w_hdr_n)));
    end else if (ready_header) begin
      r_valid_header <= 1'b0;
    end
  end

  assign valid_header = r_valid_header;
  assign data_header  = r_data_header;
  assign keep_header  = r_keep_header;

`ifdef AXIS_EXTRACT_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pkt_cnt <= '0;
    else if (w_pkt_done) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end
  assign pkt_cnt = r_pkt_cnt;
`else
  logic w_pkt_done_unused;
  assign w_pkt_done_unused = w_pkt_done;
`endif

endmodule

// File: doc/axi_stream_extract_header.md
AXI_STREAM_EXTRACT_HEADER -- requirements
Module: axi_stream_extract_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat (W).
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), header byte-count field width.
REQ-004 SHALL have the following ports:
  clk  in  1  clock, all logic rising-edge.
  rst_n  in  1  reset, asynchronous, active-low.
  valid_in, ready_in  in/out  1  input stream handshake.
  data_in  in  DATA_WD  input data; byte 0 of the stream is data_in[DATA_WD-1 -: 8] (MSB first).
  keep_in  in  DATA_BYTE_WD  byte enables, MSB-aligned contiguous.
  last_in  in  1  final beat of packet.
  byte_extract_cnt  in  BYTE_CNT_WD  header length N = byte_extract_cnt+1 bytes.
  valid_out, ready_out  out/in  1  payload stream handshake.
  data_out, keep_out, last_out  out  DATA_WD/DATA_BYTE_WD/1  realigned payload, MSB-aligned.
  valid_header, ready_header  out/in  1  header channel handshake.
  data_header  out  DATA_WD  header bytes, right-aligned (last header byte in bits [7:0]).
  keep_header  out  DATA_BYTE_WD  low-aligned enables of header bytes.

Function
REQ-005 SHALL remove the first N bytes of each packet and present them once on the header channel; the remaining bytes SHALL appear on the payload stream, first payload byte in the MSB byte of data_out.
REQ-006 SHALL sample byte_extract_cnt on the handshake of each packet's first beat and hold N for that packet.
REQ-007 SHALL implement states IDLE (await first beat), BODY (streaming), TAIL (flush residual), with a 2-bit state register.
REQ-008 IDLE: ready_in = !valid_header || ready_header; on first-beat handshake load header register, set valid_header, store residual R = W-N bytes (data_in shifted left by N bytes), go BODY.
REQ-009 First beat with last_in and B = popcount(keep_in) <= N: header carries B bytes (keep_header = (1<<B)-1), no payload beat, stay IDLE.
REQ-010 First beat with last_in and B > N: header carries N bytes; go TAIL with residual of B-N bytes.
REQ-011 BODY: valid_out = valid_in; ready_in = ready_out; data_out = residual R bytes followed by top W-R bytes of data_in; the low R bytes of data_in become the new residual; combinational path, zero added cycles, payload lags input by one beat.
REQ-012 BODY with last_in: if R + B <= W, emit the combined beat with last_out=1, keep_out = top (R+B) bits set, go IDLE; else emit full beat (keep_out all ones, last_out=0) and go TAIL holding R+B-W bytes.
REQ-013 TAIL: ready_in=0, valid_out=1, data_out = residual, keep_out = top residual-count bits, last_out=1; on handshake go IDLE.
REQ-014 N = W (R = 0): payload beats SHALL equal input beats unchanged.
REQ-015 Header channel SHALL be independent of the payload stream; valid_header clears on its handshake; a new packet SHALL NOT start while the previous header is unaccepted.
REQ-016 Byte-count arithmetic SHALL use BYTE_CNT_WD+1 bits; keep_in is trusted contiguous, non-last beats full.
REQ-017 data/keep outputs SHALL be stable while valid and not ready (AXI-Stream rule).

Reset
REQ-018 On rst_n low: state IDLE, valid_out=0, valid_header=0, residual, data_header, keep_header cleared to 0, ready_in=1 after release; reset mid-packet SHALL discard the packet.

Configuration
REQ-019 With macro AXIS_EXTRACT_PKT_CNT_EN defined, SHALL add output pkt_cnt [15:0], incremented on each last_out or header-only packet completion, wrapping at 0xFFFF->0, reset 0; without it the port and counter SHALL not exist.

Structure
REQ-020 A shared package SHALL hold state enum (IDLE, BODY, TAIL) and byte-count/mask helper functions (popcount, MSB mask of n bytes).
REQ-021 One sub-module, axis_byte_realign (residual + input combine, parameterised on W), SHALL be used.

Verification (W=4)
REQ-022 N=2, beats 0xAABBCCDD, 0x11223344 (last, keep 1111) -> header 0x0000AABB keep 0011; payload 0xCCDD1122 then 0x33440000 keep 1100 last.
REQ-023 N=2, beats 0xAABBCCDD, 0x11000000 keep 1000 last -> single payload beat 0xCCDD1100 keep 1110 last.
REQ-024 N=4, 3 full beats -> header 0xAABBCCDD keep 1111; payload = beats 2 and 3 unchanged, last on beat 3.
REQ-025 N=3, one beat 0xAABB0000 keep 1100 last -> header 0x0000AABB keep 0011, no payload beat.
REQ-026 ready_out/ready_header randomly deasserted 50% -> no data loss, outputs stable under stall; assert rst_n mid-packet -> all valids 0, next packet correct.
